// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM encoding and defaults for the round-robin arbiter
package arb_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_G0 = 2'd1, ST_G1 = 2'd2} state_t;
  function automatic state_t grant_st(input logic idx);
    return idx ? ST_G1 : ST_G0;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker, ptr breaks ties
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ptr : req[1];
endmodule

// File: rtl/arb2_8b_rr.sv
// arb2_8b_rr: packet round-robin arbiter of two sources onto one registered channel
module arb2_8b_rr
  import arb_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy,
  output logic         ovf
);
  localparam int CW = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BEATS - 1);
  state_t state, nxt;
  logic ptr;
  logic [CW-1:0] beat_cnt;
  logic grant, x, cur_valid, cur_last, oth_valid, load, acc, cap, rel, gnt_valid, gnt_idx;
  logic [W-1:0] cur_data;
  rr_pick2 u_pick (
    .req      ({in1_valid, in0_valid}),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );
  assign grant     = (state == ST_G0) || (state == ST_G1);
  assign x         = state == ST_G1;
  assign cur_valid = x ? in1_valid : in0_valid;
  assign cur_last  = x ? in1_last : in0_last;
  assign cur_data  = x ? in1_data : in0_data;
  assign oth_valid = x ? in0_valid : in1_valid;
  assign load      = ~out_valid | out_ready;
  assign acc       = grant & load & cur_valid;
  assign cap       = beat_cnt == CAP;
  assign rel       = acc & (cur_last | cap);
  assign in0_ready = (state == ST_G0) & load;
  assign in1_ready = (state == ST_G1) & load;
  assign sel       = x;
  assign busy      = grant;
  // next grant: arbitrate from idle, hand over on release, fall back to idle once a finished grant goes quiet
  always_comb begin
    nxt = !grant ? (gnt_valid ? grant_st(gnt_idx) : ST_IDLE)
        : rel ? (oth_valid ? grant_st(~x) : cur_valid ? state : ST_IDLE)
        : (beat_cnt == '0 && !cur_valid) ? ST_IDLE : state;
  end
  // grant state, fairness pointer, per-grant beat count and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= nxt;
      if (rel) begin
        ptr      <= ~x;
        beat_cnt <= '0;
      end else if (acc) beat_cnt <= beat_cnt + 1'b1;
      if (acc && cap && !cur_last) ovf <= 1'b1;
    end
  end
  // one-entry output register, held stable while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_last  <= cur_last;
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_arb2_8b_rr.sv
// tb_arb2_8b_rr: scoreboard bench with a packet-level round-robin reference model
module tb_arb2_8b_rr;
  localparam int W = 8, MB = 4;
  typedef logic [8:0] beat_t;
  logic clk = 1'b0, rst;
  logic in0_valid, in0_last, in0_ready, in1_valid, in1_last, in1_ready;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic out_valid, out_last, out_ready, sel, busy, ovf;
  beat_t q0[$], q1[$], p0[$], p1[$], exp_q[$];
  beat_t exp_b, pb;
  int compared = 0, mismatched = 0, cyc = 0;
  int fire_cyc[$];
  int lens[6] = '{1, 2, 3, 5, 6, 7};
  bit bp = 0, mon_en = 1, saw_in0_ready = 0, saw_sel1 = 0, model_ptr = 0, model_ovf = 0;
  logic pv = 1'b0, pr = 1'b0;

  arb2_8b_rr #(.W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // sources present their queue head continuously and retire it on handshake
  initial forever begin
    @(negedge clk);
    in0_valid = q0.size() != 0;
    if (q0.size() != 0) {in0_last, in0_data} = q0[0];
    #2;
    if (in0_valid && in0_ready) void'(q0.pop_front());
  end
  initial forever begin
    @(negedge clk);
    in1_valid = q1.size() != 0;
    if (q1.size() != 0) {in1_last, in1_data} = q1[0];
    #2;
    if (in1_valid && in1_ready) void'(q1.pop_front());
  end
  initial forever begin
    @(negedge clk);
    out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // monitor: compares every delivered beat against the scoreboard and checks stall stability
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && mon_en) begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_last, out_data}, pb);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_last, out_data});
        end else begin
          exp_b = exp_q.pop_front();
          chk("out_beat", {out_last, out_data}, exp_b);
        end
        fire_cyc.push_back(cyc);
      end
      if (in0_ready) saw_in0_ready = 1;
      if (sel) saw_sel1 = 1;
    end
    pv = rst ? 1'b0 : out_valid;
    pr = out_ready;
    pb = {out_last, out_data};
  end

  task automatic add_pkt(input bit src, input int len, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b = {i == len - 1, rnd ? 8'($urandom) : base + 8'(i)};
      if (src) p1.push_back(b);
      else p0.push_back(b);
    end
  endtask

  // packet-level model: alternate grant segments (packet end or MB beats) between sources
  task automatic model_phase();
    beat_t m0[$], m1[$], b;
    bit cur;
    int n;
    m0 = p0;
    m1 = p1;
    cur = (m0.size() != 0 && m1.size() != 0) ? model_ptr : (m1.size() != 0);
    while (m0.size() + m1.size() != 0) begin
      n = 0;
      do begin
        b = cur ? m1.pop_front() : m0.pop_front();
        exp_q.push_back(b);
        n++;
      end while (!b[8] && n < MB);
      if (!b[8]) model_ovf = 1;
      model_ptr = !cur;
      if ((cur ? m0.size() : m1.size()) != 0) cur = !cur;
    end
  endtask

  task automatic run_phase(input bit bpm, input int budget);
    int i;
    @(negedge clk);
    #3;
    model_phase();
    fire_cyc.delete();
    q0 = p0;
    q1 = p1;
    p0.delete();
    p1.delete();
    bp = bpm;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    bp = 0;
    repeat (3) @(negedge clk);
    q0.delete();
    q1.delete();
    exp_q.delete();
    chk("idle_busy", busy, 0);
    chk("ovf", ovf, model_ovf);
  endtask

  function automatic int span();
    return fire_cyc.size() == 0 ? -1 : fire_cyc[fire_cyc.size() - 1] - fire_cyc[0];
  endfunction

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    {in0_valid, in0_last, in1_valid, in1_last} = '0;
    in0_data = '0;
    in1_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    rst = 1'b0;
    // forced release after MB beats hands the channel to in1
    add_pkt(0, 6, 8'h60, 0);
    add_pkt(1, 1, 8'h70, 0);
    run_phase(0, 100);
    // reset in the middle of a packet clears everything at once
    mon_en = 0;
    @(negedge clk);
    #3;
    q0 = '{9'h080, 9'h081, 9'h082, 9'h083, 9'h084, 9'h085, 9'h186};
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in0_ready", in0_ready, 0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    model_ptr = 0;
    model_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1;
    // both valid from idle: whole in0 packet then in1 packet with no bubble
    add_pkt(0, 3, 8'hA0, 0);
    add_pkt(1, 2, 8'hB0, 0);
    run_phase(0, 100);
    chk("ab_span", span(), 4);
    // only in1, back-to-back single-beat packets
    saw_in0_ready = 0;
    saw_sel1 = 0;
    add_pkt(1, 1, 8'h5A, 0);
    add_pkt(1, 1, 8'h5B, 0);
    run_phase(0, 100);
    chk("in1_span", span(), 1);
    chk("in1_no_in0_ready", saw_in0_ready, 0);
    chk("in1_sel", saw_sel1, 1);
    // fairness: alternating single-beat packets from both sources
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 1, 8'h10 + 8'(i), 0);
      add_pkt(1, 1, 8'h20 + 8'(i), 0);
    end
    run_phase(0, 100);
    chk("alt_span", span(), 7);
    // randomized packets with random sink backpressure
    for (int ph = 0; ph < 40; ph++) begin
      for (int s = 0; s < 2; s++)
        for (int k = $urandom_range(0, 3); k > 0; k--)
          add_pkt(s[0], lens[$urandom_range(0, 5)], 8'h00, 1);
      run_phase($urandom_range(0, 1) != 0, 400);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
